avr_cmd_decoder: RTL
====================

# avr_cmd_decoder

Parametrised AVR command decoder for the CPLD. It replaces the fixed 7-bit set/clear command muxer with a channel-indexed decoder that supports set, clear, toggle, timed pulse and restore-defaults operations on up to 16 control lines. The AVR command strobe is synchronised into the CPLD system clock, so there is no dual-edge clocking. The block sits between the AVR control bus and the cart-side control nets (reset, sreg enable, SI, OE, WE, counter, SNES mode, spares).

## Interface
- CHANNELS, 8, number of output lines (1..16)
- RESET_VALUE, 8'b0111_1010, per-channel value after reset and after RESTORE (CHANNELS bits)
- PULSE_LEN, 4, pulse duration in clk cycles (1..255)
- SYNC_STAGES, 2, strobe synchroniser depth (2..3)
- clk  in  1  CPLD system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- avr_ctrl  in  7  command word: [6:4] opcode, [3:0] channel index
- avr_strobe  in  1  command strobe; every transition (rise or fall) issues one command
- ctrl_out  out  CHANNELS  decoded control lines
- busy  out  1  high while a pulse is in progress
- cmd_err  out  1  one-cycle flag for a rejected command
- cmd_count  out  8  accepted-command counter, wraps 255->0

## Operation
- Opcodes:
  - 000 NOP: accepted and counted, no output change.
  - 001 CLEAR: ctrl_out[ch]=0.
  - 010 SET: ctrl_out[ch]=1.
  - 011 TOGGLE: ctrl_out[ch] is inverted.
  - 100 PULSE: ctrl_out[ch] is inverted for PULSE_LEN cycles, then the pre-pulse value is restored.
  - 101 RESTORE: ctrl_out=RESET_VALUE and any active pulse is aborted; the channel field is ignored.
  - 110 and 111 are reserved and rejected.
- Rejection: cmd_err=1 for one cycle, no state change, cmd_count unchanged. The causes are:
  - a reserved opcode;
  - a channel index >= CHANNELS on opcodes 001-100;
  - PULSE while busy;
  - any 001-100 command that targets the channel currently pulsing.
- Accepted commands on other channels execute normally during a pulse.
- avr_ctrl is pipelined through SYNC_STAGES registers alongside avr_strobe. Decode uses the ctrl value sampled on the same clk edge as the strobe transition.
- Pulse engine:
  - one engine: a channel register, a saved value and a down-counter of width ceil(log2(PULSE_LEN+1));
  - busy=1 from the inversion edge until the restore edge.
- RESTORE during a pulse: outputs take RESET_VALUE, busy drops on the same edge, and the saved value is discarded.
- Arming: edge detection is disarmed after reset for SYNC_STAGES+1 cycles while the synchroniser fills. A strobe level present at reset release is never interpreted as a command.

## Timing
- Reset values: ctrl_out=RESET_VALUE, busy=0, cmd_err=0, cmd_count=0; synchroniser, ctrl pipeline and pulse counter are all 0.
- Latency: ctrl_out, cmd_err and cmd_count update on the (SYNC_STAGES+1)-th rising clk edge, counting as first the edge that first samples the new strobe level. With the default that is 3 edges.
- Pulse: the inversion lands at the latency above (edge E). The restore happens at edge E+PULSE_LEN, and busy falls on the same edge.
- A PULSE issued on the exact edge busy falls is rejected. busy is evaluated before the restore takes effect.
- Strobe rules for the AVR:
  - strobe transitions must be >= SYNC_STAGES+2 clk periods apart;
  - avr_ctrl must be stable from SYNC_STAGES+1 cycles before each strobe transition until SYNC_STAGES+1 cycles after it.
  - Closer transitions are not guaranteed to be counted separately.
- Reset asserted mid-pulse: all outputs go immediately (asynchronously) to their reset values, and the pulse is lost.
- cmd_count increments once per accepted command, 255+1=0, with no saturation.

## Test plan
- Reset with avr_strobe held high, release, wait 10 cycles -> ctrl_out=RESET_VALUE, cmd_count=0, no cmd_err.
- Issue SET ch0 (0x20) on a rising strobe, then CLEAR ch3 (0x13) on a falling strobe -> ctrl_out bit0=1 at strobe+3 cycles, bit3=0 at the second strobe+3, cmd_count=2.
- Issue PULSE ch1 (0x41) with bit1=1 -> bit1=0 and busy=1 for exactly 4 cycles, then bit1=1 and busy=0. Issue TOGGLE ch1 mid-pulse -> cmd_err for 1 cycle, bit1 still restored to 1.
- Issue PULSE ch2, then RESTORE (0x50) two cycles into the pulse -> ctrl_out=RESET_VALUE and busy=0 on the RESTORE update edge.
- Issue opcode 0x60, then SET ch9 (0x29) with CHANNELS=8 -> cmd_err pulse on each, ctrl_out and cmd_count unchanged.
- Issue 256 NOPs -> cmd_count wraps to 0. Assert reset_n mid-pulse -> immediate RESET_VALUE and busy=0.

Source files
------------

// File: rtl/avr_cmd_decoder_if.sv
// AVR command/status bundle: master is the AVR side, slave is the decoder.
// Latency: none (wires only); backpressure: none, the AVR paces its own strobes.
interface avr_cmd_decoder_if #(
  parameter int CHANNELS = 8
);
  logic [6:0]          avr_ctrl;
  logic                avr_strobe;
  logic [CHANNELS-1:0] ctrl_out;
  logic                busy;
  logic                cmd_err;
  logic [7:0]          cmd_count;

  modport master (
    output avr_ctrl, avr_strobe,
    input  ctrl_out, busy, cmd_err, cmd_count
  );

  modport slave (
    input  avr_ctrl, avr_strobe,
    output ctrl_out, busy, cmd_err, cmd_count
  );
endinterface

// File: rtl/avr_cmd_decoder.sv
// Channel-indexed AVR command decoder (set/clear/toggle/pulse/restore). Latency SYNC_STAGES+1 clk
// edges from first strobe sample; no backpressure, unacceptable commands are dropped and flagged on cmd_err.
module avr_cmd_decoder #(
  parameter int                  CHANNELS    = 8,
  parameter logic [CHANNELS-1:0] RESET_VALUE = 8'b0111_1010,
  parameter int                  PULSE_LEN   = 4,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  avr_cmd_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CLEAR   = 3'd1,
    OP_SET     = 3'd2,
    OP_TOGGLE  = 3'd3,
    OP_PULSE   = 3'd4,
    OP_RESTORE = 3'd5,
    OP_RSVD6   = 3'd6,
    OP_RSVD7   = 3'd7
  } op_e;

  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } pulse_st_e;

  // Strobe synchroniser and ctrl pipeline of equal depth keep the command word aligned
  // with the strobe sample that carries it.
  logic [SYNC_STAGES-1:0]      strobe_sync;
  logic                        strobe_prev;
  logic [SYNC_STAGES-1:0][6:0] ctrl_pipe;
  logic [ARM_W-1:0]            arm_cnt;

  logic [CHANNELS-1:0]         ctrl_q;
  logic                        err_q;
  logic [7:0]                  count_q;

  pulse_st_e                   pulse_st;
  logic [3:0]                  pulse_ch;
  logic                        pulse_saved;
  logic [CNT_W-1:0]            pulse_cnt;

  logic [6:0]                  cmd_word;
  op_e                         op;
  logic [3:0]                  ch;
  logic                        cmd_vld;
  logic                        is_chan_op;
  logic                        ch_ok;
  logic                        pulsing;
  logic                        pulse_done;
  logic                        reject;
  logic                        accept;
  logic [CHANNELS-1:0]         ch_mask;
  logic [CHANNELS-1:0]         pulse_mask;
  logic                        cur_bit;
  logic [CHANNELS-1:0]         ctrl_nxt;

  always_comb begin
    cmd_word   = ctrl_pipe[SYNC_STAGES-1];
    op         = op_e'(cmd_word[6:4]);
    ch         = cmd_word[3:0];
    cmd_vld    = (arm_cnt == ARM_DONE) && (strobe_sync[SYNC_STAGES-1] != strobe_prev);
    is_chan_op = (op == OP_CLEAR) || (op == OP_SET) || (op == OP_TOGGLE) || (op == OP_PULSE);
    ch_ok      = ({1'b0, ch} < 5'(CHANNELS));
    pulsing    = (pulse_st == PS_ACTIVE);
    pulse_done = pulsing && (pulse_cnt == CNT_W'(1));
  end

  // Rejection uses the busy state from before this edge, so a PULSE landing on the
  // restore edge still sees the engine as occupied.
  always_comb begin
    reject = 1'b0;
    if (cmd_vld) begin
      if ((op == OP_RSVD6) || (op == OP_RSVD7)) begin
        reject = 1'b1;
      end
      if (is_chan_op && !ch_ok) begin
        reject = 1'b1;
      end
      if ((op == OP_PULSE) && pulsing) begin
        reject = 1'b1;
      end
      if (is_chan_op && pulsing && (ch == pulse_ch)) begin
        reject = 1'b1;
      end
    end
    accept = cmd_vld && !reject;
  end

  always_comb begin
    ch_mask    = '0;
    pulse_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_mask[i]    = (ch == 4'(i));
      pulse_mask[i] = (pulse_ch == 4'(i));
    end
    cur_bit = |(ctrl_q & ch_mask);
  end

  // Pulse restore is applied first; an accepted command never targets the pulsing
  // channel, so the two can only collide through RESTORE, which must win.
  always_comb begin
    ctrl_nxt = ctrl_q;
    if (pulse_done) begin
      ctrl_nxt = (ctrl_nxt & ~pulse_mask) | (pulse_saved ? pulse_mask : '0);
    end
    if (accept) begin
      case (op)
        OP_CLEAR:   ctrl_nxt = ctrl_nxt & ~ch_mask;
        OP_SET:     ctrl_nxt = ctrl_nxt | ch_mask;
        OP_TOGGLE:  ctrl_nxt = ctrl_nxt ^ ch_mask;
        OP_PULSE:   ctrl_nxt = ctrl_nxt ^ ch_mask;
        OP_RESTORE: ctrl_nxt = RESET_VALUE;
        default:    ctrl_nxt = ctrl_nxt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_sync <= '0;
      strobe_prev <= 1'b0;
      ctrl_pipe   <= '0;
      arm_cnt     <= '0;
      ctrl_q      <= RESET_VALUE;
      err_q       <= 1'b0;
      count_q     <= 8'd0;
      pulse_st    <= PS_IDLE;
      pulse_ch    <= 4'd0;
      pulse_saved <= 1'b0;
      pulse_cnt   <= '0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], bus.avr_strobe};
      strobe_prev <= strobe_sync[SYNC_STAGES-1];
      ctrl_pipe   <= {ctrl_pipe[SYNC_STAGES-2:0], bus.avr_ctrl};
      // Stays disarmed until the synchroniser holds real strobe samples, so a level
      // present at reset release never reads as a transition.
      if (arm_cnt != ARM_DONE) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end

      ctrl_q <= ctrl_nxt;
      err_q  <= reject;
      if (accept) begin
        count_q <= count_q + 8'd1;
      end

      case (pulse_st)
        PS_IDLE: begin
          if (accept && (op == OP_PULSE)) begin
            pulse_st    <= PS_ACTIVE;
            pulse_ch    <= ch;
            pulse_saved <= cur_bit;
            pulse_cnt   <= CNT_W'(PULSE_LEN);
          end
        end
        PS_ACTIVE: begin
          if (accept && (op == OP_RESTORE)) begin
            pulse_st    <= PS_IDLE;
            pulse_saved <= 1'b0;
            pulse_cnt   <= '0;
          end else begin
            pulse_cnt <= pulse_cnt - CNT_W'(1);
            if (pulse_done) begin
              pulse_st <= PS_IDLE;
            end
          end
        end
        default: pulse_st <= PS_IDLE;
      endcase
    end
  end

  assign bus.ctrl_out  = ctrl_q;
  assign bus.busy      = (pulse_st == PS_ACTIVE);
  assign bus.cmd_err   = err_q;
  assign bus.cmd_count = count_q;

endmodule
